multi_commit_completion_buffer: RTL and testbench

// - In-order retirement buffer for the out-of-order backend; successor to the single-port, single-commit buffer.
// - Decode allocates one entry per issued instruction, tail first.
// - NUM_WB functional units write results back by index, in any order.
// - Retires up to COMMIT_WIDTH consecutive completed entries per cycle to the register file.
// - Precise exceptions: an excepting entry retires alone at head, reports its cause and EPC, and flushes the buffer.

---
 rtl/multi_commit_completion_buffer_pkg.sv | 20 ++
 rtl/multi_commit_completion_buffer_if.sv | 55 +++++
 rtl/multi_commit_completion_buffer_commit_select.sv | 37 +++
 rtl/multi_commit_completion_buffer.sv | 169 ++++++++++++++++
 tb/tb_multi_commit_completion_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_commit_completion_buffer_pkg.sv
// Shared types for the multi-commit completion buffer: entry record and
// default field widths.
package cb_pkg;

  localparam int unsigned CB_DATA_W  = 32;
  localparam int unsigned CB_CAUSE_W = 4;
  localparam int unsigned CB_RD_W    = 5;

  // One buffer entry; data doubles as the EPC when exception is set.
  typedef struct packed {
    logic [CB_DATA_W-1:0]  data;
    logic [CB_RD_W-1:0]    rd;
    logic [CB_CAUSE_W-1:0] cause;
    logic                  allocated;
    logic                  valid;
    logic                  wen;
    logic                  exception;
  } cb_entry_t;

endpackage

// File: rtl/multi_commit_completion_buffer_if.sv
// Bundle of the allocate / writeback / commit / exception signals of the
// completion buffer. master = decode + functional units, slave = buffer.
interface multi_commit_completion_buffer_if
  import cb_pkg::*;
#(
  parameter int unsigned NUM_ENTRY    = 16,
  parameter int unsigned NUM_WB       = 4,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned DATA_W       = CB_DATA_W,
  parameter int unsigned CAUSE_W      = CB_CAUSE_W
);
  localparam int unsigned IDX_W = $clog2(NUM_ENTRY);

  logic                             alloc_valid;
  logic                             alloc_ready;
  logic [IDX_W-1:0]                 alloc_index;

  logic [NUM_WB-1:0]                wb_valid;
  logic [NUM_WB*IDX_W-1:0]          wb_index;
  logic [NUM_WB*DATA_W-1:0]         wb_data;
  logic [NUM_WB*CB_RD_W-1:0]        wb_rd;
  logic [NUM_WB-1:0]                wb_wen;
  logic [NUM_WB-1:0]                wb_exception;
  logic [NUM_WB*CAUSE_W-1:0]        wb_cause;

  logic                             flush_in;

  logic [COMMIT_WIDTH-1:0]          commit_valid;
  logic [COMMIT_WIDTH*CB_RD_W-1:0]  commit_rd;
  logic [COMMIT_WIDTH*DATA_W-1:0]   commit_data;
  logic [COMMIT_WIDTH-1:0]          commit_wen;

  logic                             exc_valid;
  logic [CAUSE_W-1:0]               exc_cause;
  logic [DATA_W-1:0]                exc_epc;

  logic [IDX_W:0]                   count;
  logic                             empty;
  logic                             full;

  modport master (
    output alloc_valid, wb_valid, wb_index, wb_data, wb_rd, wb_wen,
           wb_exception, wb_cause, flush_in,
    input  alloc_ready, alloc_index, commit_valid, commit_rd, commit_data,
           commit_wen, exc_valid, exc_cause, exc_epc, count, empty, full
  );

  modport slave (
    input  alloc_valid, wb_valid, wb_index, wb_data, wb_rd, wb_wen,
           wb_exception, wb_cause, flush_in,
    output alloc_ready, alloc_index, commit_valid, commit_rd, commit_data,
           commit_wen, exc_valid, exc_cause, exc_epc, count, empty, full
  );

endinterface

// File: rtl/multi_commit_completion_buffer_commit_select.sv
// Retirement selector: looks at the COMMIT_WIDTH entries starting at head
// and picks the longest run of completed, non-excepting entries.
module cb_commit_select
  import cb_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned CNT_W        = 5
) (
  input  cb_entry_t               i_ent [COMMIT_WIDTH],
  input  logic [CNT_W-1:0]        i_count,
  output logic [COMMIT_WIDTH-1:0] o_commit_valid,
  output logic [CNT_W-1:0]        o_ncommit,
  output logic                    o_exc_head
);

  logic w_chain;

  // Prefix-AND chain: the first ineligible slot blocks every slot above it.
  always_comb begin
    w_chain        = 1'b1;
    o_commit_valid = '0;
    o_ncommit      = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      w_chain = w_chain & i_ent[k].allocated & i_ent[k].valid &
                ~i_ent[k].exception & (CNT_W'(k) < i_count);
      o_commit_valid[k] = w_chain;
      o_ncommit         = o_ncommit + CNT_W'(w_chain);
    end
  end

  // A completed excepting entry at head retires alone and forces a flush.
  always_comb begin
    o_exc_head = i_ent[0].allocated & i_ent[0].valid & i_ent[0].exception &
                 (i_count != '0);
  end

endmodule

// File: rtl/multi_commit_completion_buffer.sv
// In-order completion buffer with NUM_WB out-of-order writeback ports and
// up to COMMIT_WIDTH retirements per cycle. Excepting entries retire alone
// at head and flush the whole buffer on the following edge.
module multi_commit_completion_buffer
  import cb_pkg::*;
#(
  parameter int unsigned NUM_ENTRY    = 16,
  parameter int unsigned NUM_WB       = 4,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned DATA_W       = CB_DATA_W,
  parameter int unsigned CAUSE_W      = CB_CAUSE_W
) (
  input logic                             clk,
  input logic                             rst,
  multi_commit_completion_buffer_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(NUM_ENTRY);
  localparam int unsigned PTR_W    = IDX_W + 1;
  localparam int unsigned WB_SEL_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [PTR_W-1:0]        r_count;
  cb_entry_t               r_ent [NUM_ENTRY];

  logic                    w_full;
  logic                    w_alloc;
  logic                    w_exc;
  logic                    w_flush;
  cb_entry_t               w_snap [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] w_cv_raw;
  logic [COMMIT_WIDTH-1:0] w_cv;
  logic [PTR_W-1:0]        w_ncommit_raw;
  logic [PTR_W-1:0]        w_ncommit;
  logic [NUM_ENTRY-1:0]    w_commit_clr;
  logic [NUM_ENTRY-1:0]    w_wb_hit;
  logic [WB_SEL_W-1:0]     w_wb_sel [NUM_ENTRY];

  // Pointer status: full when index bits match but the wrap bits differ.
  always_comb begin
    w_full  = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
              (r_head[IDX_W] != r_tail[IDX_W]);
    w_flush = w_exc | bus.flush_in;
    w_alloc = bus.alloc_valid & ~w_full & ~w_flush;
  end

  // Entries at head..head+COMMIT_WIDTH-1, wrapping modulo NUM_ENTRY.
  always_comb begin
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      w_snap[k] = r_ent[r_head[IDX_W-1:0] + IDX_W'(k)];
    end
  end

  cb_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .CNT_W        (PTR_W)
  ) u_commit_select (
    .i_ent          (w_snap),
    .i_count        (r_count),
    .o_commit_valid (w_cv_raw),
    .o_ncommit      (w_ncommit_raw),
    .o_exc_head     (w_exc)
  );

  // External flush discards this cycle's retirements; an exception at head
  // already blocks slot 0, so only flush_in needs masking here.
  always_comb begin
    w_cv         = bus.flush_in ? '0 : w_cv_raw;
    w_ncommit    = bus.flush_in ? '0 : w_ncommit_raw;
    w_commit_clr = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (w_cv[k]) begin
        w_commit_clr[r_head[IDX_W-1:0] + IDX_W'(k)] = 1'b1;
      end
    end
  end

  // Writeback decode per entry; ports are scanned high to low so the lowest
  // numbered port hitting an index is the one that lands.
  always_comb begin
    w_wb_hit = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      w_wb_sel[i] = '0;
    end
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      for (int unsigned q = 0; q < NUM_WB; q++) begin
        if (bus.wb_valid[NUM_WB-1-q] &&
            bus.wb_index[(NUM_WB-1-q)*IDX_W +: IDX_W] == IDX_W'(i)) begin
          w_wb_hit[i] = 1'b1;
          w_wb_sel[i] = WB_SEL_W'(NUM_WB-1-q);
        end
      end
    end
  end

  // Head/tail/count bookkeeping; any flush empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_ncommit;
      r_tail  <= r_tail + PTR_W'(w_alloc);
      r_count <= r_count + PTR_W'(w_alloc) - w_ncommit;
    end
  end

  // Entry storage: retire clears, writeback fills allocated entries,
  // allocation opens the entry at tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
        r_ent[i] <= '0;
      end
    end else if (w_flush) begin
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
        if (w_commit_clr[i]) begin
          r_ent[i] <= '0;
        end else if (w_wb_hit[i] && r_ent[i].allocated) begin
          r_ent[i] <= '{
            data:      CB_DATA_W'(bus.wb_data[w_wb_sel[i]*DATA_W +: DATA_W]),
            rd:        bus.wb_rd[w_wb_sel[i]*CB_RD_W +: CB_RD_W],
            cause:     CB_CAUSE_W'(bus.wb_cause[w_wb_sel[i]*CAUSE_W +: CAUSE_W]),
            allocated: 1'b1,
            valid:     1'b1,
            wen:       bus.wb_wen[w_wb_sel[i]],
            exception: bus.wb_exception[w_wb_sel[i]]
          };
        end else if (w_alloc && r_tail[IDX_W-1:0] == IDX_W'(i)) begin
          r_ent[i] <= '{allocated: 1'b1, default: '0};
        end
      end
    end
  end

  // Commit, exception and status outputs; payloads are zero when not valid.
  always_comb begin
    bus.commit_valid = w_cv;
    bus.commit_wen   = '0;
    bus.commit_rd    = '0;
    bus.commit_data  = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      if (w_cv[k]) begin
        bus.commit_rd[k*CB_RD_W +: CB_RD_W]  = w_snap[k].rd;
        bus.commit_data[k*DATA_W +: DATA_W]  = DATA_W'(w_snap[k].data);
        bus.commit_wen[k]                    = w_snap[k].wen;
      end
    end
    bus.exc_valid   = w_exc;
    bus.exc_cause   = w_exc ? CAUSE_W'(w_snap[0].cause) : '0;
    bus.exc_epc     = w_exc ? DATA_W'(w_snap[0].data) : '0;
    bus.alloc_ready = ~w_full;
    bus.alloc_index = r_tail[IDX_W-1:0];
    bus.count       = r_count;
    bus.empty       = (r_count == '0);
    bus.full        = w_full;
  end

endmodule

// File: tb/tb_multi_commit_completion_buffer.sv
// Directed bench for multi_commit_completion_buffer. Expected retirements
// and exceptions are queued when stimulus is issued; a negedge monitor pops
// and compares them whenever the buffer presents a commit or exception.
module tb_multi_commit_completion_buffer;

  localparam int unsigned NE  = 16;
  localparam int unsigned NW  = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned CAW = 4;
  localparam int unsigned IW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_commit_completion_buffer_if #(
    .NUM_ENTRY(NE), .NUM_WB(NW), .COMMIT_WIDTH(CW), .DATA_W(DW), .CAUSE_W(CAW)
  ) bus ();

  multi_commit_completion_buffer #(
    .NUM_ENTRY(NE), .NUM_WB(NW), .COMMIT_WIDTH(CW), .DATA_W(DW), .CAUSE_W(CAW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
  } cexp_t;

  typedef struct {
    logic [3:0]  cause;
    logic [31:0] epc;
  } eexp_t;

  cexp_t cq[$];
  eexp_t eq[$];
  int    checks = 0;
  int    errors = 0;
  int unsigned ord [3] = '{3, 1, 2};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.alloc_valid  = 1'b0;
    bus.wb_valid     = '0;
    bus.wb_index     = '0;
    bus.wb_data      = '0;
    bus.wb_rd        = '0;
    bus.wb_wen       = '0;
    bus.wb_exception = '0;
    bus.wb_cause     = '0;
    bus.flush_in     = 1'b0;
  endtask

  task automatic wb(input int unsigned p, input logic [3:0] idx, input logic [31:0] data,
                    input logic [4:0] rd, input logic wen, input logic exc,
                    input logic [3:0] cause);
    bus.wb_valid[p]            = 1'b1;
    bus.wb_index[p*IW +: IW]   = idx;
    bus.wb_data[p*DW +: DW]    = data;
    bus.wb_rd[p*5 +: 5]        = rd;
    bus.wb_wen[p]              = wen;
    bus.wb_exception[p]        = exc;
    bus.wb_cause[p*CAW +: CAW] = cause;
  endtask

  task automatic push_c(input logic [4:0] rd, input logic [31:0] data, input logic wen);
    cexp_t e;
    e.rd = rd; e.data = data; e.wen = wen;
    cq.push_back(e);
  endtask

  task automatic push_e(input logic [3:0] cause, input logic [31:0] epc);
    eexp_t e;
    e.cause = cause; e.epc = epc;
    eq.push_back(e);
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int unsigned n);
    bus.alloc_valid = 1'b1;
    repeat (n) step();
    bus.alloc_valid = 1'b0;
  endtask

  // Scoreboard monitor: every presented retirement/exception must match the
  // oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < CW; k++) begin
        if (bus.commit_valid[k]) begin
          if (cq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit slot=%0d actual rd=%0d data=0x%0h expected no commit",
                     k, bus.commit_rd[k*5 +: 5], bus.commit_data[k*DW +: DW]);
          end else begin
            cexp_t e;
            e = cq.pop_front();
            chk("commit_data", 64'(bus.commit_data[k*DW +: DW]), 64'(e.data));
            chk("commit_rd",   64'(bus.commit_rd[k*5 +: 5]),     64'(e.rd));
            chk("commit_wen",  64'(bus.commit_wen[k]),           64'(e.wen));
          end
        end
      end
      if (bus.exc_valid) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_exc actual cause=%0h epc=0x%0h expected no exception",
                   bus.exc_cause, bus.exc_epc);
        end else begin
          eexp_t e;
          e = eq.pop_front();
          chk("exc_cause", 64'(bus.exc_cause), 64'(e.cause));
          chk("exc_epc",   64'(bus.exc_epc),   64'(e.epc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    mid();
    chk("rst_count",       64'(bus.count),        64'd0);
    chk("rst_empty",       64'(bus.empty),        64'd1);
    chk("rst_full",        64'(bus.full),         64'd0);
    chk("rst_alloc_ready", 64'(bus.alloc_ready),  64'd1);
    chk("rst_alloc_index", 64'(bus.alloc_index),  64'd0);
    chk("rst_commit",      64'(bus.commit_valid), 64'd0);
    chk("rst_exc",         64'(bus.exc_valid),    64'd0);
    step();

    // 1. Reset mid-traffic
    alloc_n(5);
    mid();
    chk("t1_count5", 64'(bus.count), 64'd5);
    step();
    wb(0, 4'd0, 32'h11, 5'd1, 1'b1, 1'b0, 4'h0);
    rst = 1'b1;
    mid();
    chk("t1_rst_count",  64'(bus.count),        64'd0);
    chk("t1_rst_empty",  64'(bus.empty),        64'd1);
    chk("t1_rst_ready",  64'(bus.alloc_ready),  64'd1);
    chk("t1_rst_commit", 64'(bus.commit_valid), 64'd0);
    step();
    clr_in();
    rst = 1'b0;
    mid();
    chk("t1_after_commit", 64'(bus.commit_valid), 64'd0);
    chk("t1_after_count",  64'(bus.count),        64'd0);
    step();

    // 2. Out-of-order writeback
    for (int unsigned i = 0; i < 4; i++) begin
      bus.alloc_valid = 1'b1;
      mid();
      chk("t2_alloc_index", 64'(bus.alloc_index), 64'(i));
      step();
    end
    bus.alloc_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      push_c(5'(10 + i), 32'(32'h200 + i), (i != 2));
    end
    for (int unsigned j = 0; j < 3; j++) begin
      wb(0, 4'(ord[j]), 32'(32'h200 + ord[j]), 5'(10 + ord[j]), (ord[j] != 2), 1'b0, 4'h0);
      mid();
      chk("t2_hold", 64'(bus.commit_valid), 64'd0);
      step();
      clr_in();
    end
    mid();
    chk("t2_hold_last", 64'(bus.commit_valid), 64'd0);
    wb(0, 4'd0, 32'h200, 5'd10, 1'b1, 1'b0, 4'h0);
    step();
    clr_in();
    mid();
    chk("t2_pair01",  64'(bus.commit_valid), 64'h3);
    chk("t2_count4",  64'(bus.count),        64'd4);
    step();
    mid();
    chk("t2_pair23",  64'(bus.commit_valid), 64'h3);
    chk("t2_count2",  64'(bus.count),        64'd2);
    step();
    mid();
    chk("t2_empty",   64'(bus.empty),        64'd1);
    chk("t2_idle",    64'(bus.commit_valid), 64'd0);
    step();

    // 3. Fill and wrap
    do_reset();
    for (int unsigned i = 0; i < NE; i++) begin
      bus.alloc_valid = 1'b1;
      mid();
      chk("t3_alloc_index", 64'(bus.alloc_index), 64'(i));
      step();
    end
    bus.alloc_valid = 1'b0;
    mid();
    chk("t3_full",    64'(bus.full),        64'd1);
    chk("t3_ready0",  64'(bus.alloc_ready), 64'd0);
    chk("t3_count16", 64'(bus.count),       64'd16);
    step();
    bus.alloc_valid = 1'b1;
    wb(0, 4'd0, 32'h300, 5'd1, 1'b1, 1'b0, 4'h0);
    wb(1, 4'd1, 32'h301, 5'd2, 1'b1, 1'b0, 4'h0);
    push_c(5'd1, 32'h300, 1'b1);
    push_c(5'd2, 32'h301, 1'b1);
    step();
    bus.wb_valid = '0;
    mid();
    chk("t3_retire2",     64'(bus.commit_valid), 64'h3);
    chk("t3_still_full",  64'(bus.full),         64'd1);
    chk("t3_still_block", 64'(bus.alloc_ready),  64'd0);
    step();
    mid();
    chk("t3_count14",   64'(bus.count),       64'd14);
    chk("t3_wrap_idx",  64'(bus.alloc_index), 64'd0);
    chk("t3_not_full",  64'(bus.full),        64'd0);
    step();
    bus.alloc_valid = 1'b0;
    mid();
    chk("t3_count15",  64'(bus.count),       64'd15);
    chk("t3_next_idx", 64'(bus.alloc_index), 64'd1);
    step();

    // 4. Exception at head+1
    do_reset();
    alloc_n(2);
    wb(0, 4'd0, 32'h40,  5'd4, 1'b1, 1'b0, 4'h0);
    wb(1, 4'd1, 32'h100, 5'd7, 1'b1, 1'b1, 4'h2);
    push_c(5'd4, 32'h40, 1'b1);
    push_e(4'h2, 32'h100);
    step();
    clr_in();
    mid();
    chk("t4_A_commit", 64'(bus.commit_valid), 64'h1);
    chk("t4_A_exc",    64'(bus.exc_valid),    64'd0);
    step();
    mid();
    chk("t4_B_exc",    64'(bus.exc_valid),    64'd1);
    chk("t4_B_epc",    64'(bus.exc_epc),      64'h100);
    chk("t4_B_cause",  64'(bus.exc_cause),    64'h2);
    chk("t4_B_commit", 64'(bus.commit_valid), 64'd0);
    chk("t4_B_count",  64'(bus.count),        64'd1);
    step();
    mid();
    chk("t4_C_count",  64'(bus.count),        64'd0);
    chk("t4_C_exc",    64'(bus.exc_valid),    64'd0);
    chk("t4_C_empty",  64'(bus.empty),        64'd1);
    step();

    // 5. Same-index writeback on two ports
    do_reset();
    alloc_n(6);
    for (int unsigned i = 0; i < 4; i++) begin
      wb(i, 4'(i), 32'(32'h500 + i), 5'(20 + i), 1'b1, 1'b0, 4'h0);
      push_c(5'(20 + i), 32'(32'h500 + i), 1'b1);
    end
    step();
    clr_in();
    wb(0, 4'd5, 32'hAA, 5'd5,  1'b1, 1'b0, 4'h0);
    wb(2, 4'd5, 32'hBB, 5'd6,  1'b1, 1'b0, 4'h0);
    wb(1, 4'd4, 32'h44, 5'd24, 1'b1, 1'b0, 4'h0);
    push_c(5'd24, 32'h44, 1'b1);
    push_c(5'd5,  32'hAA, 1'b1);
    step();
    clr_in();
    for (int n = 0; n < 10 && !bus.empty; n++) step();
    mid();
    chk("t5_drained", 64'(bus.empty), 64'd1);
    step();

    // 6. External flush with concurrent alloc and writeback
    do_reset();
    alloc_n(3);
    wb(0, 4'd0, 32'h600, 5'd3, 1'b1, 1'b0, 4'h0);
    step();
    clr_in();
    bus.flush_in    = 1'b1;
    bus.alloc_valid = 1'b1;
    wb(1, 4'd1, 32'h601, 5'd4, 1'b1, 1'b0, 4'h0);
    mid();
    chk("t6_flush_commit", 64'(bus.commit_valid), 64'd0);
    chk("t6_flush_count",  64'(bus.count),        64'd3);
    step();
    clr_in();
    mid();
    chk("t6_count0",   64'(bus.count),        64'd0);
    chk("t6_idx0",     64'(bus.alloc_index),  64'd0);
    chk("t6_commit0",  64'(bus.commit_valid), 64'd0);
    chk("t6_empty",    64'(bus.empty),        64'd1);
    step();
    step();

    chk("sb_commit_drain", 64'(cq.size()), 64'd0);
    chk("sb_exc_drain",    64'(eq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
